// File: rtl/bsg_mcl_slot_bridge_pkg.sv
// Shared types and helpers for the multi-slot width bridge.
// Optional feature macro (used by the lane and top): BSG_MCL_SLOT_BRIDGE_PERF_EN.
package bsg_mcl_slot_bridge_pkg;

  localparam int mcl_word_width_gp = 32;
  localparam int rcv_th_gp         = 2;

  // Downsizer (PISO) state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } piso_state_e;

  // Number of host words per manycore packet
  function automatic int ratio(input int pkt_width, input int word_width);
    return pkt_width / word_width;
  endfunction

endpackage

// File: rtl/bsg_mcl_slot_bridge_lane.sv
// One slot of the width bridge: word->packet upsizer, receive FIFO with
// vacancy counter and threshold flag, and packet->word PISO downsizer.
// Optional per-slot performance counters under BSG_MCL_SLOT_BRIDGE_PERF_EN.
module bsg_mcl_slot_bridge_lane
  import bsg_mcl_slot_bridge_pkg::*;
#(
  parameter int word_width_p   = mcl_word_width_gp,
  parameter int pkt_width_p    = 128,
  parameter int rcv_fifo_els_p = 4,
  parameter int rcv_th_p       = rcv_th_gp,
  localparam int vac_w_lp      = $clog2(rcv_fifo_els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    h2m_v_i,
  input  logic [word_width_p-1:0] h2m_data_i,
  output logic                    h2m_ready_o,
  input  logic                    h2m_flush_i,
  output logic                    m2e_v_o,
  output logic [pkt_width_p-1:0]  m2e_data_o,
  input  logic                    m2e_ready_i,
  input  logic                    e2m_v_i,
  input  logic [pkt_width_p-1:0]  e2m_data_i,
  output logic                    e2m_ready_o,
  output logic                    m2h_v_o,
  output logic [word_width_p-1:0] m2h_data_o,
  input  logic                    m2h_yumi_i,
  output logic [vac_w_lp-1:0]     rcv_vacancy_o,
  output logic                    rcv_th_o
`ifdef BSG_MCL_SLOT_BRIDGE_PERF_EN
  , output logic [31:0]           h2m_pkt_cnt_o
  , output logic [31:0]           m2h_pkt_cnt_o
  , output logic [31:0]           flush_cnt_o
`endif
);

  localparam int ratio_lp = ratio(pkt_width_p, word_width_p);
  localparam int cnt_w_lp = $clog2(ratio_lp + 1);
  localparam int idx_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int ptr_w_lp = $clog2(rcv_fifo_els_p);

  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(ratio_lp);
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(ratio_lp - 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(rcv_fifo_els_p - 1);
  localparam logic [vac_w_lp-1:0] vac_max_lp  = vac_w_lp'(rcv_fifo_els_p);

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_last_lp) begin
      return '0;
    end else begin
      return p + ptr_w_lp'(1);
    end
  endfunction

  // ---------------- Upsizer ----------------
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [pkt_width_p-1:0] pkt_q, pkt_d;
  logic                   m2e_v_q, m2e_v_d;
  logic                   h2m_acc;
  logic                   m2e_hs;

  // While a full packet waits, no word is accepted; a flush drops the word offered with it
  assign h2m_ready_o = (cnt_q != cnt_full_lp) & ~h2m_flush_i;
  assign h2m_acc     = h2m_v_i & h2m_ready_o;
  assign m2e_hs      = m2e_v_q & m2e_ready_i;
  assign m2e_v_o     = m2e_v_q;
  assign m2e_data_o  = pkt_q;

  // Word counter and packet assembly; flush wins over the packet handshake
  always_comb begin
    cnt_d = cnt_q;
    pkt_d = pkt_q;
    if (h2m_flush_i) begin
      cnt_d = '0;
    end else if (m2e_hs) begin
      cnt_d = '0;
    end else if (h2m_acc) begin
      cnt_d = cnt_q + cnt_w_lp'(1);
      for (int k = 0; k < ratio_lp; k++) begin
        if (cnt_q == cnt_w_lp'(k)) begin
          pkt_d[k*word_width_p +: word_width_p] = h2m_data_i;
        end else begin
          pkt_d[k*word_width_p +: word_width_p] = pkt_q[k*word_width_p +: word_width_p];
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
    m2e_v_d = (cnt_d == cnt_full_lp);
  end

  // Upsizer state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      pkt_q   <= '0;
      m2e_v_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      m2e_v_q <= m2e_v_d;
    end
  end

  // ---------------- Receive FIFO and vacancy ----------------
  logic [pkt_width_p-1:0] mem_q [rcv_fifo_els_p];
  logic [ptr_w_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [vac_w_lp-1:0]    vac_q, vac_d;
  logic                   rcv_th_q, rcv_th_d;
  logic                   enq, deq, fifo_empty;

  assign e2m_ready_o   = (vac_q != '0);
  assign enq           = e2m_v_i & e2m_ready_o;
  assign fifo_empty    = (vac_q == vac_max_lp);
  assign rcv_vacancy_o = vac_q;
  assign rcv_th_o      = rcv_th_q;

  // Pointer, vacancy and threshold next state; enqueue+dequeue leaves vacancy unchanged
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    vac_d  = vac_q;
    if (enq) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (deq) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({enq, deq})
      2'b10:   vac_d = vac_q - vac_w_lp'(1);
      2'b01:   vac_d = vac_q + vac_w_lp'(1);
      default: vac_d = vac_q;
    endcase
    rcv_th_d = (32'(vac_d) < 32'(rcv_th_p));
  end

  // FIFO storage write port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < rcv_fifo_els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[wptr_q] <= e2m_data_i;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      vac_q    <= vac_max_lp;
      rcv_th_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      vac_q    <= vac_d;
      rcv_th_q <= rcv_th_d;
    end
  end

  // ---------------- PISO downsizer ----------------
  piso_state_e              state_q, state_d;
  logic [idx_w_lp-1:0]      idx_q, idx_d;
  logic [pkt_width_p-1:0]   buf_q, buf_d;
  logic [word_width_p-1:0]  buf_words [ratio_lp];

  for (genvar k = 0; k < ratio_lp; k++) begin : g_words
    assign buf_words[k] = buf_q[k*word_width_p +: word_width_p];
  end

  assign m2h_v_o    = (state_q == SEND);
  assign m2h_data_o = buf_words[idx_q];

  // PISO next state; reloads on the final yumi so back-to-back packets have no bubble
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    deq     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          deq     = 1'b1;
          buf_d   = mem_q[rptr_q];
          idx_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (m2h_yumi_i) begin
          if (idx_q == idx_last_lp) begin
            idx_d = '0;
            if (!fifo_empty) begin
              deq     = 1'b1;
              buf_d   = mem_q[rptr_q];
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + idx_w_lp'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // PISO state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

`ifdef BSG_MCL_SLOT_BRIDGE_PERF_EN
  logic [31:0] h2m_pkt_cnt_q, m2h_pkt_cnt_q, flush_cnt_q;
  logic        m2h_last_yumi;

  assign m2h_last_yumi = (state_q == SEND) & m2h_yumi_i & (idx_q == idx_last_lp);
  assign h2m_pkt_cnt_o = h2m_pkt_cnt_q;
  assign m2h_pkt_cnt_o = m2h_pkt_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

  // Wrapping event counters: packets out, packets returned to host, flushes
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h2m_pkt_cnt_q <= 32'd0;
      m2h_pkt_cnt_q <= 32'd0;
      flush_cnt_q   <= 32'd0;
    end else begin
      h2m_pkt_cnt_q <= h2m_pkt_cnt_q + {31'd0, m2e_hs};
      m2h_pkt_cnt_q <= m2h_pkt_cnt_q + {31'd0, m2h_last_yumi};
      flush_cnt_q   <= flush_cnt_q + {31'd0, h2m_flush_i};
    end
  end
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: rtl/bsg_mcl_slot_width_bridge.sv
// Multi-slot width bridge between 32-bit host word FIFOs and wide manycore
// packet FIFOs. Each slot is an independent bsg_mcl_slot_bridge_lane.
// Optional per-slot counters under BSG_MCL_SLOT_BRIDGE_PERF_EN.
module bsg_mcl_slot_width_bridge
  import bsg_mcl_slot_bridge_pkg::*;
#(
  parameter int num_slots_p    = 2,
  parameter int word_width_p   = mcl_word_width_gp,
  parameter int pkt_width_p    = 128,
  parameter int rcv_fifo_els_p = 4,
  parameter int rcv_th_p       = rcv_th_gp,
  localparam int vac_w_lp      = $clog2(rcv_fifo_els_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_slots_p-1:0]              h2m_v_i,
  input  logic [num_slots_p*word_width_p-1:0] h2m_data_i,
  output logic [num_slots_p-1:0]              h2m_ready_o,
  input  logic [num_slots_p-1:0]              h2m_flush_i,
  output logic [num_slots_p-1:0]              m2e_v_o,
  output logic [num_slots_p*pkt_width_p-1:0]  m2e_data_o,
  input  logic [num_slots_p-1:0]              m2e_ready_i,
  input  logic [num_slots_p-1:0]              e2m_v_i,
  input  logic [num_slots_p*pkt_width_p-1:0]  e2m_data_i,
  output logic [num_slots_p-1:0]              e2m_ready_o,
  output logic [num_slots_p-1:0]              m2h_v_o,
  output logic [num_slots_p*word_width_p-1:0] m2h_data_o,
  input  logic [num_slots_p-1:0]              m2h_yumi_i,
  output logic [num_slots_p*vac_w_lp-1:0]     rcv_vacancy_o,
  output logic [num_slots_p-1:0]              rcv_th_o
`ifdef BSG_MCL_SLOT_BRIDGE_PERF_EN
  , output logic [num_slots_p*32-1:0]         h2m_pkt_cnt_o
  , output logic [num_slots_p*32-1:0]         m2h_pkt_cnt_o
  , output logic [num_slots_p*32-1:0]         flush_cnt_o
`endif
);

  for (genvar s = 0; s < num_slots_p; s++) begin : g_slot
    bsg_mcl_slot_bridge_lane #(
      .word_width_p   (word_width_p),
      .pkt_width_p    (pkt_width_p),
      .rcv_fifo_els_p (rcv_fifo_els_p),
      .rcv_th_p       (rcv_th_p)
    ) u_lane (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .h2m_v_i       (h2m_v_i[s]),
      .h2m_data_i    (h2m_data_i[s*word_width_p +: word_width_p]),
      .h2m_ready_o   (h2m_ready_o[s]),
      .h2m_flush_i   (h2m_flush_i[s]),
      .m2e_v_o       (m2e_v_o[s]),
      .m2e_data_o    (m2e_data_o[s*pkt_width_p +: pkt_width_p]),
      .m2e_ready_i   (m2e_ready_i[s]),
      .e2m_v_i       (e2m_v_i[s]),
      .e2m_data_i    (e2m_data_i[s*pkt_width_p +: pkt_width_p]),
      .e2m_ready_o   (e2m_ready_o[s]),
      .m2h_v_o       (m2h_v_o[s]),
      .m2h_data_o    (m2h_data_o[s*word_width_p +: word_width_p]),
      .m2h_yumi_i    (m2h_yumi_i[s]),
      .rcv_vacancy_o (rcv_vacancy_o[s*vac_w_lp +: vac_w_lp]),
      .rcv_th_o      (rcv_th_o[s])
`ifdef BSG_MCL_SLOT_BRIDGE_PERF_EN
      , .h2m_pkt_cnt_o (h2m_pkt_cnt_o[s*32 +: 32])
      , .m2h_pkt_cnt_o (m2h_pkt_cnt_o[s*32 +: 32])
      , .flush_cnt_o   (flush_cnt_o[s*32 +: 32])
`endif
    );
  end

endmodule

// File: doc/bsg_mcl_slot_width_bridge.md
Name: bsg_mcl_slot_width_bridge

Overview:
- Parametrised, multi-slot width bridge between the host-side 32-bit word FIFOs and the wide manycore packet FIFOs of the AXIL/manycore link.
- Generalises the per-slot upsizer, receive buffer, vacancy counter and downsizer to N slots, arbitrary word/packet ratio and buffer depth.
- Adds per-slot partial-packet flush and a receive-threshold flag.
- Sits between the AXIL-to-FIFO adapter and the manycore endpoint-to-FIFO adapter.

Parameters:
- num_slots_p, 2, number of independent slots; each slot has a host-to-MC path and an MC-to-host path.
- word_width_p, 32, host-side word width.
- pkt_width_p, 128, manycore packet width; must be a multiple of word_width_p.
- rcv_fifo_els_p, 4, receive FIFO depth per slot, at least 2.
- rcv_th_p, 2, rcv_th_o asserts when vacancy < rcv_th_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- h2m_v_i  in  N  host word valid.
- h2m_data_i  in  N*word_width_p  host word.
- h2m_ready_o  out  N  word accept.
- h2m_flush_i  in  N  discard the partially assembled packet.
- m2e_v_o  out  N  assembled packet valid.
- m2e_data_o  out  N*pkt_width_p  assembled packet.
- m2e_ready_i  in  N  endpoint accepts the packet.
- e2m_v_i  in  N  returned packet valid.
- e2m_data_i  in  N*pkt_width_p  returned packet.
- e2m_ready_o  out  N  receive FIFO not full.
- m2h_v_o  out  N  host word valid.
- m2h_data_o  out  N*word_width_p  host word.
- m2h_yumi_i  in  N  host consumes the word; legal only while m2h_v_o is high.
- rcv_vacancy_o  out  N*`BSG_WIDTH(rcv_fifo_els_p)  free receive FIFO entries.
- rcv_th_o  out  N  vacancy < rcv_th_p.

Behaviour:
- Interface: one clock, clk_i; reset_n_i is asynchronous and active-low.
- Reset values: all word counters 0, all FIFOs empty, all valids 0, rcv_vacancy_o = rcv_fifo_els_p, rcv_th_o = 0.
- Reset mid-operation discards all partial and buffered data.
- R = pkt_width_p / word_width_p. All slots are fully independent.
- Upsizer (per slot):
  - Counter cnt runs 0..R.
  - h2m_ready_o = (cnt != R) & ~h2m_flush_i.
  - An accepted word k lands in bits [k*W +: W]; word 0 is the LSBs.
  - m2e_v_o = (cnt == R), registered; packet valid appears one cycle after its last word is accepted.
  - A handshake on m2e sets cnt to 0 next cycle; there is no same-cycle word accept while full.
  - h2m_flush_i sets cnt to 0 next cycle, drops any word presented that cycle, and clears m2e_v_o even if the packet is complete. Flush has priority over the m2e handshake.
  - R = 1 degenerates to a one-entry register.
- Receive FIFO (per slot):
  - 1r1w, depth rcv_fifo_els_p, no bypass.
  - e2m_ready_o = ~full; enqueue on e2m_v_i & e2m_ready_o.
  - Dequeue when the PISO loads.
- Vacancy: decrement on enqueue, increment on dequeue, unchanged when both occur in one cycle. Range 0..rcv_fifo_els_p, never wraps.
- PISO (per slot):
  - States IDLE and SEND, with word index idx.
  - IDLE, FIFO non-empty -> load the head, dequeue, go to SEND with idx = 0.
  - SEND: m2h_v_o = 1 and m2h_data_o = word idx. m2h_yumi_i advances idx.
  - Yumi on word R-1: if the FIFO is non-empty, load the next packet in the same cycle (zero-bubble, stay in SEND); otherwise go to IDLE.
  - m2h_v_o is 0 in IDLE.
- Boundaries:
  - Full FIFO with a simultaneous enqueue/dequeue is not allowed, because ready_o is computed from the registered full flag.
  - Empty FIFO: the PISO stays IDLE.

Optional Feature:
- Macro: BSG_MCL_SLOT_BRIDGE_PERF_EN.
- When defined:
  - Adds per-slot 32-bit wrapping counters h2m_pkt_cnt_o (m2e handshakes) and m2h_pkt_cnt_o (final-word yumis), plus flush_cnt_o.
  - All counters reset to 0.
- When undefined: these ports and their logic are absent, with identical functional behaviour otherwise.

Decomposition:
- Shared package bsg_mcl_slot_bridge_pkg holds:
  - PISO state enum (IDLE, SEND).
  - Function ratio(pkt_width, word_width).
  - Default constants mcl_word_width_gp = 32 and rcv_th_gp.
- One sub-module, bsg_mcl_slot_bridge_lane, implements a single slot (upsizer, FIFO, vacancy, PISO). The top generates num_slots_p lanes and slices the packed buses.

Test Plan:
1. R=4, slot0, send words 0x0,0x1,0x2,0x3 with m2e_ready_i=1 -> m2e_data_o = 0x00000003_00000002_00000001_00000000, valid one cycle after the 4th word; h2m_ready_o is low for exactly that cycle.
2. Send 2 words, assert h2m_flush_i with a word present, then send 4 words 0xA..0xD -> a single packet 0x0000000D_0000000C_0000000B_0000000A; the flushed word is never accepted.
3. rcv_fifo_els_p=4, m2h_yumi_i=0, push 4 packets -> vacancy 4,3,2,1,0; e2m_ready_o=0 at 0; rcv_th_o high when vacancy ≤ 1 (rcv_th_p=2).
4. Two packets buffered, yumi held high continuously -> 8 consecutive m2h words with no bubble between packets; vacancy returns to 4.
5. Simultaneous enqueue and PISO load at vacancy 2 -> vacancy stays 2.
6. Assert reset_n_i low mid-packet on both slots, asynchronously -> all valids drop immediately, vacancy = 4; after release, a fresh 4-word packet is assembled correctly.
